// File: rtl/phase_monitor_ctrl.sv
// ---------------------------------------------------------------------------
// phase_monitor_ctrl
//   Sequencer for the analog-core phase monitor. For one sign setting
//   (sel_cfg) or all four (sweep_all), it holds the monitor flops in clear,
//   lets them settle, then counts ff_in / ff_ref highs over a 2^N_SAMP_LOG2
//   cycle window. The counts are stored per setting for register readout.
//
//   Build option: define PM_CTRL_SYNC2_EN to pass ff_in/ff_ref through a
//   two-flop synchronizer (2-cycle latency). Without it, a single register
//   stage is used (1-cycle latency). The state sequence and done timing are
//   the same in both builds.
//
// Ports
//   clk          core clock, rising edge
//   rstb         asynchronous active-low reset
//   start        run request (level, honoured in IDLE only)
//   abort        terminate the current run, no done
//   sweep_all    1: settings 0..3, 0: sel_cfg only (sampled with start)
//   sel_cfg      sign setting for single-setting runs
//   ff_in/ff_ref monitor sample outputs (asynchronous)
//   en_sync      monitor flop clear, active low
//   sel_sign     monitor sign select
//   busy         run in progress
//   done         one-cycle completion pulse
//   cnt_in_all   ff_in count per setting, slice k = setting k
//   cnt_ref_all  ff_ref count per setting, slice k = setting k
// ---------------------------------------------------------------------------
module phase_monitor_ctrl #(
    parameter int N_SAMP_LOG2 = 10,
    parameter int CNT_W       = N_SAMP_LOG2 + 1,
    parameter int CLR_CYC     = 4,
    parameter int SETTLE_CYC  = 8
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic               start,
    input  logic               abort,
    input  logic               sweep_all,
    input  logic [1:0]         sel_cfg,
    input  logic               ff_in,
    input  logic               ff_ref,
    output logic               en_sync,
    output logic [1:0]         sel_sign,
    output logic               busy,
    output logic               done,
    output logic [4*CNT_W-1:0] cnt_in_all,
    output logic [4*CNT_W-1:0] cnt_ref_all
);

    localparam int ACC_CYC = 1 << N_SAMP_LOG2;
    localparam int MAX_A   = (ACC_CYC > SETTLE_CYC) ? ACC_CYC : SETTLE_CYC;
    localparam int TMR_MAX = (MAX_A > CLR_CYC) ? MAX_A : CLR_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX);

    // Timer is loaded with (length - 1) and the state ends when it hits 0.
    localparam logic [TMR_W-1:0] CLR_LD = TMR_W'(CLR_CYC - 1);
    localparam logic [TMR_W-1:0] SET_LD = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] ACC_LD = TMR_W'(ACC_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_SETTLE, S_ACCUM, S_STORE, S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [TMR_W-1:0]          tmr_q, tmr_d;
    logic [1:0]                sel_q, sel_d;
    logic                      sweep_q, sweep_d;
    logic                      en_sync_q, en_sync_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    // Request capture stage: start is sampled at edge 0 and acted on at
    // edge 1, so CLEAR begins one cycle after the request edge. A request
    // that coincides with abort is dropped here.
    logic                      start_q;
    logic                      pend_sweep_q;
    logic [1:0]                pend_sel_q;

    logic [CNT_W-1:0]          wrk_in_q, wrk_ref_q;
    logic [3:0][CNT_W-1:0]     slc_in_q, slc_ref_q;
    logic                      smp_in, smp_ref;
    logic                      abort_run;

    assign abort_run = abort && (state_q != S_IDLE);

    // ---------------------------------------------------------------- samples
`ifdef PM_CTRL_SYNC2_EN
    logic [1:0] sync_in_q, sync_ref_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sync_in_q  <= '0;
            sync_ref_q <= '0;
        end else begin
            sync_in_q  <= {sync_in_q[0], ff_in};
            sync_ref_q <= {sync_ref_q[0], ff_ref};
        end
    end

    assign smp_in  = sync_in_q[1];
    assign smp_ref = sync_ref_q[1];
`else
    logic smp_in_q, smp_ref_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            smp_in_q  <= 1'b0;
            smp_ref_q <= 1'b0;
        end else begin
            smp_in_q  <= ff_in;
            smp_ref_q <= ff_ref;
        end
    end

    assign smp_in  = smp_in_q;
    assign smp_ref = smp_ref_q;
`endif

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q      <= S_IDLE;
            tmr_q        <= '0;
            sel_q        <= '0;
            sweep_q      <= 1'b0;
            en_sync_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            start_q      <= 1'b0;
            pend_sweep_q <= 1'b0;
            pend_sel_q   <= '0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            sel_q        <= sel_d;
            sweep_q      <= sweep_d;
            en_sync_q    <= en_sync_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            start_q      <= start && !abort;
            pend_sweep_q <= sweep_all;
            pend_sel_q   <= sel_cfg;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        sel_d   = sel_q;
        sweep_d = sweep_q;

        case (state_q)
            S_IDLE: begin
                if (start_q && !abort) begin
                    state_d = S_CLEAR;
                    tmr_d   = CLR_LD;
                    sweep_d = pend_sweep_q;
                    sel_d   = pend_sweep_q ? 2'd0 : pend_sel_q;
                end
            end
            S_CLEAR: begin
                if (tmr_q == '0) begin
                    state_d = S_SETTLE;
                    tmr_d   = SET_LD;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_SETTLE: begin
                if (tmr_q == '0) begin
                    state_d = S_ACCUM;
                    tmr_d   = ACC_LD;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_ACCUM: begin
                if (tmr_q == '0) begin
                    state_d = S_STORE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_STORE: begin
                if (sweep_q && (sel_q != 2'd3)) begin
                    state_d = S_CLEAR;
                    tmr_d   = CLR_LD;
                    sel_d   = sel_q + 2'd1;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort_run) begin
            state_d = S_IDLE;
        end

        // Outputs are registered from the next state so the analog-facing
        // controls never see decode glitches. en_sync stays high through
        // STORE so it is low only for the CLEAR cycles of each setting.
        en_sync_d = (state_d == S_SETTLE) || (state_d == S_ACCUM) ||
                    (state_d == S_STORE);
        busy_d    = (state_d == S_CLEAR) || (state_d == S_SETTLE) ||
                    (state_d == S_ACCUM) || (state_d == S_STORE);
        done_d    = (state_d == S_DONE);
    end

    // -------------------------------------------------------------- counters
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wrk_in_q  <= '0;
            wrk_ref_q <= '0;
            slc_in_q  <= '0;
            slc_ref_q <= '0;
        end else begin
            if (abort_run || (state_q == S_STORE)) begin
                wrk_in_q  <= '0;
                wrk_ref_q <= '0;
            end else if (state_q == S_ACCUM) begin
                // Saturate rather than wrap.
                if (smp_in && (wrk_in_q != CNT_MAX)) begin
                    wrk_in_q <= wrk_in_q + 1'b1;
                end
                if (smp_ref && (wrk_ref_q != CNT_MAX)) begin
                    wrk_ref_q <= wrk_ref_q + 1'b1;
                end
            end

            if ((state_q == S_STORE) && !abort) begin
                slc_in_q[sel_q]  <= wrk_in_q;
                slc_ref_q[sel_q] <= wrk_ref_q;
            end
        end
    end

    assign en_sync     = en_sync_q;
    assign sel_sign    = sel_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cnt_in_all  = slc_in_q;
    assign cnt_ref_all = slc_ref_q;

endmodule

// File: tb/tb_phase_monitor_ctrl.sv
// ---------------------------------------------------------------------------
// tb_phase_monitor_ctrl
//   Directed vectors with hand-computed expectations. Each completing run
//   pushes its expected done edge and count vectors into a queue; a monitor
//   process pops and compares whenever done is high. Abort/reset behaviour
//   and control outputs are checked directly at chosen edges.
// ---------------------------------------------------------------------------
module tb_phase_monitor_ctrl;

    localparam int NL    = 10;
    localparam int CW    = NL + 1;
    localparam int P     = 4 + 8 + 1024 + 1;   // cycles per setting
    localparam int T1    = 1 + P;              // 1038
    localparam int T4    = 1 + 4 * P;          // 4149

    logic          clk = 1'b0;
    logic          rstb;
    logic          start, abort, sweep_all;
    logic [1:0]    sel_cfg;
    logic          ff_in, ff_in_lvl, ff_ref, tog, tog_en;
    logic          en_sync, busy, done;
    logic [1:0]    sel_sign;
    logic [4*CW-1:0] cnt_in_all, cnt_ref_all;

    int edge_n = 0;
    int checks = 0;
    int errors = 0;
    int m_in[4];
    int m_ref[4];

    typedef struct {
        int              edge_n;
        logic [4*CW-1:0] in_all;
        logic [4*CW-1:0] ref_all;
    } exp_t;

    exp_t sb[$];

    phase_monitor_ctrl #(
        .N_SAMP_LOG2(NL), .CNT_W(CW), .CLR_CYC(4), .SETTLE_CYC(8)
    ) dut (
        .clk(clk), .rstb(rstb), .start(start), .abort(abort),
        .sweep_all(sweep_all), .sel_cfg(sel_cfg),
        .ff_in(ff_in), .ff_ref(ff_ref),
        .en_sync(en_sync), .sel_sign(sel_sign), .busy(busy), .done(done),
        .cnt_in_all(cnt_in_all), .cnt_ref_all(cnt_ref_all)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n++;
    always @(negedge clk) tog = tog_en ? ~tog : 1'b0;
    assign ff_in = tog_en ? tog : ff_in_lvl;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d edge=%0d", nm, act, exp, edge_n);
        end
    endtask

    function automatic logic [4*CW-1:0] pack_in();
        logic [4*CW-1:0] r;
        for (int k = 0; k < 4; k++) r[k*CW +: CW] = CW'(m_in[k]);
        return r;
    endfunction

    function automatic logic [4*CW-1:0] pack_ref();
        logic [4*CW-1:0] r;
        for (int k = 0; k < 4; k++) r[k*CW +: CW] = CW'(m_ref[k]);
        return r;
    endfunction

    task automatic push(input int at);
        exp_t e;
        e.edge_n  = at;
        e.in_all  = pack_in();
        e.ref_all = pack_ref();
        sb.push_back(e);
    endtask

    task automatic wait_to(input int target);
        while (edge_n < target) @(negedge clk);
    endtask

    // Call at a negedge; e is the edge that samples start (edge 0).
    task automatic run_start(input logic sw, input logic [1:0] sc, output int e);
        sweep_all = sw;
        sel_cfg   = sc;
        start     = 1'b1;
        e         = edge_n + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done edge=%0d", edge_n);
            end else begin
                e = sb.pop_front();
                chk("done_edge", 64'(edge_n), 64'(e.edge_n));
                chk("busy_at_done", 64'(busy), 64'(0));
                chk("cnt_in_all", 64'(cnt_in_all), 64'(e.in_all));
                chk("cnt_ref_all", 64'(cnt_ref_all), 64'(e.ref_all));
            end
        end
    end

    initial begin
        int e, base, x;
        rstb = 1'b1; start = 1'b0; abort = 1'b0; sweep_all = 1'b0;
        sel_cfg = 2'd0; ff_in_lvl = 1'b0; ff_ref = 1'b0; tog_en = 1'b0;
        for (int k = 0; k < 4; k++) begin m_in[k] = 0; m_ref[k] = 0; end

        // Reset state
        @(negedge clk); rstb = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_en_sync", 64'(en_sync), 64'(0));
        chk("rst_sel_sign", 64'(sel_sign), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_cnt_in", 64'(cnt_in_all), 64'(0));
        chk("rst_cnt_ref", 64'(cnt_ref_all), 64'(0));
        rstb = 1'b1;
        @(negedge clk);

        // A: single run, setting 2, ff_in=1 ff_ref=0
        ff_in_lvl = 1'b1; ff_ref = 1'b0;
        m_in[2] = 1024; m_ref[2] = 0;
        run_start(1'b0, 2'd2, e);
        push(e + T1);
        wait_to(e + 2);
        chk("A_sel", 64'(sel_sign), 64'(2));
        chk("A_busy", 64'(busy), 64'(1));
        chk("A_en_clear", 64'(en_sync), 64'(0));
        wait_to(e + 600);
        chk("A_sel_mid", 64'(sel_sign), 64'(2));
        chk("A_en_accum", 64'(en_sync), 64'(1));
        wait_to(e + T1 + 2);
        chk("A_sb_drained", 64'(sb.size()), 64'(0));

        // B: sweep, ff_in toggling, ff_ref=1; en_sync low exactly 4 cycles
        ff_ref = 1'b1; tog_en = 1'b1;
        for (int k = 0; k < 4; k++) begin m_in[k] = 512; m_ref[k] = 1024; end
        run_start(1'b1, 2'd2, e);
        push(e + T4);
        for (int k = 0; k < 4; k++) begin
            base = e + 1 + k * P;
            if (k > 0) begin
                wait_to(base - 1);
                chk("B_en_store", 64'(en_sync), 64'(1));
            end
            wait_to(base);
            chk("B_sel", 64'(sel_sign), 64'(k));
            chk("B_en_clr0", 64'(en_sync), 64'(0));
            wait_to(base + 3);
            chk("B_en_clr3", 64'(en_sync), 64'(0));
            wait_to(base + 4);
            chk("B_en_settle", 64'(en_sync), 64'(1));
        end
        wait_to(e + T4 + 2);
        chk("B_sb_drained", 64'(sb.size()), 64'(0));
        tog_en = 1'b0;

        // C: pulses during CLEAR/SETTLE ignored, 5 ff_ref highs in ACCUM
        ff_in_lvl = 1'b0; ff_ref = 1'b0;
        @(negedge clk);
        m_in[1] = 0; m_ref[1] = 5;
        run_start(1'b0, 2'd1, e);
        push(e + T1);
        wait_to(e + 1);   ff_in_lvl = 1'b1;
        wait_to(e + 9);   ff_in_lvl = 1'b0;
        wait_to(e + 100); ff_ref = 1'b1;
        wait_to(e + 105); ff_ref = 1'b0;
        wait_to(e + T1 + 2);
        chk("C_sb_drained", 64'(sb.size()), 64'(0));

        // D: abort mid-ACCUM of setting 1 in a sweep
        ff_in_lvl = 1'b1; ff_ref = 1'b0;
        run_start(1'b1, 2'd0, e);
        m_in[0] = 1024; m_ref[0] = 0;
        x = e + 1 + P + 12 + 500;
        wait_to(x); abort = 1'b1;
        wait_to(x + 1); abort = 1'b0;
        chk("D_busy", 64'(busy), 64'(0));
        chk("D_en_sync", 64'(en_sync), 64'(0));
        chk("D_done", 64'(done), 64'(0));
        wait_to(x + 40);
        chk("D_busy_idle", 64'(busy), 64'(0));
        chk("D_cnt_in", 64'(cnt_in_all), 64'(pack_in()));
        chk("D_cnt_ref", 64'(cnt_ref_all), 64'(pack_ref()));

        // E: start re-pulsed while busy is ignored
        ff_in_lvl = 1'b0; ff_ref = 1'b1;
        m_in[3] = 0; m_ref[3] = 1024;
        run_start(1'b0, 2'd3, e);
        push(e + T1);
        wait_to(e + 50);  start = 1'b1; sweep_all = 1'b1; sel_cfg = 2'd0;
        wait_to(e + 51);  start = 1'b0;
        wait_to(e + 500); start = 1'b1;
        wait_to(e + 501); start = 1'b0;
        wait_to(e + 600);
        chk("E_sel", 64'(sel_sign), 64'(3));
        wait_to(e + T1 + 2);
        chk("E_sb_drained", 64'(sb.size()), 64'(0));

        // abort + start together in IDLE
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("AS_busy", 64'(busy), 64'(0));
        repeat (4) @(negedge clk);
        chk("AS_busy_late", 64'(busy), 64'(0));
        chk("AS_en_sync", 64'(en_sync), 64'(0));

        // F: reset mid-ACCUM, then a normal run
        ff_in_lvl = 1'b1; ff_ref = 1'b1;
        run_start(1'b0, 2'd0, e);
        wait_to(e + 500);
        rstb = 1'b0;
        #1;
        chk("F_en_sync", 64'(en_sync), 64'(0));
        chk("F_sel", 64'(sel_sign), 64'(0));
        chk("F_busy", 64'(busy), 64'(0));
        chk("F_done", 64'(done), 64'(0));
        chk("F_cnt_in", 64'(cnt_in_all), 64'(0));
        chk("F_cnt_ref", 64'(cnt_ref_all), 64'(0));
        for (int k = 0; k < 4; k++) begin m_in[k] = 0; m_ref[k] = 0; end
        repeat (2) @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        m_in[0] = 1024; m_ref[0] = 1024;
        run_start(1'b0, 2'd0, e);
        push(e + T1);
        wait_to(e + T1 + 2);
        chk("F_sb_drained", 64'(sb.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/phase_monitor_ctrl.md
# phase_monitor_ctrl

Sequencer for the analog-core phase monitor sub-block. Drives its sign-select and synchronous-enable controls, then counts the `ff_in` and `ff_ref` samples it returns over a fixed window for one or all four sign settings. Results feed the JTAG/register readout used for PI phase calibration. One instance per phase monitor; runs in the digital core clock domain.

## Interface
Parameters:
- `N_SAMP_LOG2`, 10: accumulation window is 2^N_SAMP_LOG2 cycles.
- `CNT_W`, N_SAMP_LOG2+1: result counter width; holds full scale 2^N_SAMP_LOG2.
- `CLR_CYC`, 4: cycles `en_sync` is held low per setting; must be ≥1.
- `SETTLE_CYC`, 8: discard cycles after `en_sync` rises; must be ≥3.

Ports:
- `clk` in, 1: core clock; all logic on the rising edge.
- `rstb` in, 1: asynchronous active-low reset.
- `start` in, 1: level-sampled run request; honoured only in IDLE.
- `abort` in, 1: terminates a run; return to IDLE without `done`.
- `sweep_all` in, 1: 1 runs settings 0..3; 0 runs only `sel_cfg`. Sampled with `start`.
- `sel_cfg` in, 2: sign setting for single-setting runs.
- `ff_in` in, 1: monitor sample output (asynchronous to `clk`).
- `ff_ref` in, 1: monitor sample output (asynchronous to `clk`).
- `en_sync` out, 1: monitor flop clear (active low).
- `sel_sign` out, 2: monitor sign select.
- `busy` out, 1: high from the cycle after `start` is accepted until `done` or abort.
- `done` out, 1: one-cycle pulse when the run completes.
- `cnt_in_all` out, 4*CNT_W: slice k holds the `ff_in` count for setting k.
- `cnt_ref_all` out, 4*CNT_W: slice k holds the `ff_ref` count for setting k.

## Operation
- Reset values: `en_sync`=0, `sel_sign`=0, `busy`=0, `done`=0, all count slices 0, state IDLE.
- States: IDLE → CLEAR → SETTLE → ACCUM → STORE → (CLEAR for next setting | DONE) → IDLE.
- IDLE: `en_sync`=0. When `start`=1, latch `sweep_all`/`sel_cfg`, set `sel_sign` to 0 (sweep) or `sel_cfg`, go to CLEAR.
- CLEAR: `en_sync`=0 for CLR_CYC cycles. `sel_sign` is stable for the whole state.
- SETTLE: `en_sync`=1 for SETTLE_CYC cycles. Samples are ignored.
- ACCUM: `en_sync`=1 for 2^N_SAMP_LOG2 cycles. Each cycle, increment the working counters where the conditioned `ff_in`/`ff_ref` equals 1. Counters are CNT_W wide and never wrap.
- STORE: one cycle. Write the working counts into slice `sel_sign` and clear the working counters. In a sweep with `sel_sign`<3, increment `sel_sign` and go to CLEAR. Otherwise go to DONE.
- DONE: `done`=1 for one cycle, `busy` drops in the same cycle, `en_sync`=0, go to IDLE.
- Slices not written during a run keep their previous values.
- `abort`=1 in any non-IDLE state: next cycle IDLE, `en_sync`=0, `busy`=0, no `done`. Working counters clear; stored slices are not modified.
- `abort` and `start` together in IDLE: `abort` wins and `start` is ignored.
- `start` while busy is ignored. `start` held high after DONE starts a new run.

## Timing
- `start` sampled at edge 0. CLEAR is active from edge 1.
- Per-setting length P = CLR_CYC + SETTLE_CYC + 2^N_SAMP_LOG2 + 1.
- `done` is high in the cycle beginning at edge 1 + K·P, where K = 1 (single) or 4 (sweep). With defaults: 1038 single, 4149 sweep.
- Slice k updates on the edge leaving STORE and is stable from the following cycle.
- `ff_in`/`ff_ref` conditioning latency is covered by SETTLE; no sample taken during CLEAR/SETTLE is counted.

## Configuration
- Macro `PM_CTRL_SYNC2_EN`:
  - Defined: `ff_in` and `ff_ref` each pass through a two-flop synchronizer (reset to 0 by `rstb`) before counting; sample-to-count latency is 2 cycles.
  - Undefined: a single register (latency 1) is used. Only for simulation or when the monitor outputs are already synchronous.
- State sequence and `done` timing are identical in both builds.

## Test plan
- Single run, `sel_cfg`=2, `ff_in`=1, `ff_ref`=0 constant → `sel_sign`=2 throughout; slice 2 of `cnt_in_all` = 1024, slice 2 of `cnt_ref_all` = 0; `done` at cycle 1038; other slices unchanged.
- Sweep, `ff_in` toggling every cycle, `ff_ref`=1 → `sel_sign` steps 0,1,2,3 at P-cycle intervals; every `cnt_in` slice = 512, every `cnt_ref` slice = 1024; `done` at cycle 4149.
- `en_sync` check → low exactly CLR_CYC=4 cycles at the start of each setting; `ff_in` pulses injected during CLEAR/SETTLE are not counted.
- `abort` pulsed in the middle of ACCUM of setting 1 in a sweep → IDLE next cycle; `busy`=0, `en_sync`=0, no `done`; slice 0 holds the new value, slices 1–3 hold prior values.
- `start` re-pulsed while busy → ignored, `done` still at cycle 1038. `abort`+`start` together in IDLE → stays IDLE.
- `rstb` asserted mid-ACCUM → all outputs at reset values immediately; a run after release completes normally.
